// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains an async_fifo read port into a valid/ready stream via a 3-entry elastic buffer.
// Define FIFO_STREAM_READER_CNT_EN to add the 16-bit xfer_cnt accepted-word counter output.
module fifo_stream_reader #(
    parameter int    DSIZE       = 8,
    parameter string FALLTHROUGH = "TRUE"
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [1:0]       occ
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    localparam bit REG_MODE = (FALLTHROUGH != "TRUE");

    logic [1:0]       wp_r;
    logic [1:0]       rp_r;
    logic [1:0]       occ_r;
    logic             inflight_r;
    logic [DSIZE-1:0] buf_r [3];

    logic [2:0]       level_s;
    logic             rinc_s;
    logic             push_s;
    logic             pop_s;
    logic [DSIZE-1:0] head_s;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts words already buffered plus the one still coming out of a registered FIFO.
    always_comb begin
        level_s = {1'b0, occ_r} + {2'b00, inflight_r};
        rinc_s  = rrst_n & ~rempty & (level_s < 3'd3);
        pop_s   = (occ_r != 2'd0) & m_ready;
        if (REG_MODE) begin
            push_s = inflight_r;
        end else begin
            push_s = rinc_s;
        end
    end

    // Head-of-buffer select for the downstream data.
    always_comb begin
        case (rp_r)
            2'd0:    head_s = buf_r[0];
            2'd1:    head_s = buf_r[1];
            2'd2:    head_s = buf_r[2];
            default: head_s = {DSIZE{1'b0}};
        endcase
    end

    // Pointer, occupancy and in-flight state.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wp_r       <= 2'd0;
            rp_r       <= 2'd0;
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            if (push_s) begin
                wp_r <= ptr_inc(wp_r);
            end else begin
                wp_r <= wp_r;
            end
            if (pop_s) begin
                rp_r <= ptr_inc(rp_r);
            end else begin
                rp_r <= rp_r;
            end
            occ_r      <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
            inflight_r <= REG_MODE ? rinc_s : 1'b0;
        end
    end

    // Buffer storage, cleared on reset so m_data reads zero.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_r[i] <= {DSIZE{1'b0}};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push_s && (wp_r == 2'(i))) begin
                    buf_r[i] <= rdata;
                end else begin
                    buf_r[i] <= buf_r[i];
                end
            end
        end
    end

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [15:0] xfer_cnt_r;

    // Accepted-word counter, wraps naturally at 16 bits.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            xfer_cnt_r <= 16'd0;
        end else if (pop_s) begin
            xfer_cnt_r <= xfer_cnt_r + 16'd1;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign xfer_cnt = xfer_cnt_r;
`endif

    assign rinc    = rinc_s;
    assign m_valid = (occ_r != 2'd0);
    assign m_data  = head_s;
    assign occ     = occ_r;

endmodule
